time_parameters: RTL and testbench
==================================

Name: time_parameters

Overview:
Programmable register file holding the three timing intervals of the traffic-light controller: base, extended and yellow, each 4 bits, in seconds. An operator port reprograms any interval at run time. The light-sequencing FSM selects an interval code and receives the stored value on a registered output, which feeds its countdown timer.

Parameters:
WIDTH, 4, bit width of every interval value and of input/output value ports
DEF_BASE, 6, reset value of base interval (tBASE)
DEF_EXT, 3, reset value of extended interval (tEXT)
DEF_YEL, 2, reset value of yellow interval (tYEL)

Ports:
clk  input  1  system clock, all state on rising edge
global_reset  input  1  asynchronous, active-low reset
time_param_selector  input  2  interval to reprogram: 0 base, 1 ext, 2 yel, 3 reserved
input_time_value  input  WIDTH  new value for the selected interval
reprogram  input  1  write strobe, sampled each rising edge (level, one write per high cycle)
fsm_requested_interval  input  2  interval to read: 0 base, 1 ext, 2 yel, 3 reserved
output_time_value  output  WIDTH  registered value of the requested interval

Behaviour:
- Interface: one clock clk; global_reset is asynchronous and active-low.
- global_reset low, asynchronously: base=DEF_BASE, ext=DEF_EXT, yel=DEF_YEL, output_time_value=DEF_BASE. This holds regardless of clk and inputs. State is released on the first rising edge after deassertion.
- Write: on a rising edge with reprogram=1, the register chosen by time_param_selector loads input_time_value.
  - Selector 3: no register changes.
  - No width conversion; the value is stored as given.
- Read: on every rising edge, output_time_value loads reg[fsm_requested_interval]. Latency is 1 cycle from the request change.
  - Request 3 loads DEF_BASE (safe fallback), not 0.
- Simultaneous write and read of the same register on one edge: the output loads the new input_time_value (write-through bypass). Other registers are unaffected.
- A value of 0 is stored as written unless the optional feature below is enabled.
- reprogram held high for several cycles rewrites every cycle; the last value wins.
- Reset mid-operation discards all programmed values and returns to the defaults.
- There is no other state machine; the block is a pure register file.

Optional Feature:
TIMEPARAM_ZERO_GUARD_EN
- Defined: a write with input_time_value==0 loads the parameter's default (DEF_*) instead of 0. The write-through bypass applies the same substitution. This prevents a zero-length light phase.
- Undefined: 0 is stored literally.

Decomposition:
- Package time_param_pkg holds:
  - interval codes: IDX_BASE=0, IDX_EXT=1, IDX_YEL=2, IDX_RSVD=3
  - default constants and a WIDTH-based value typedef, shared with the FSM and timer.
- One natural sub-module: time_param_reg, a single WIDTH register with async active-low reset to a parameterised default and a write enable. It is instantiated three times. Read mux, bypass and zero-guard stay in the top.

Test Plan:
- Reset: drive global_reset low mid-cycle -> output_time_value=6 immediately. After release with request 0 -> output stays 6. Request 1 -> output 3 one edge later. Request 2 -> output 2.
- Reprogram ext: reprogram=1, selector=1, value=9 for one cycle, request=1 -> output 9 on that same edge (bypass) and afterwards. Request 0 -> output 6.
- Reprogram base: reprogram=1, selector=0, value=12, request=0 -> output 12. Ext still reads 9 and yel still reads 2.
- Reserved codes: write with selector=3, value=15 -> no register changes. Request 3 -> output 6.
- Reset after programming: base=12, ext=9, then assert global_reset -> output 6, and reading ext gives 3.
- Zero write: selector=2, value=0 -> yel reads 0 without the macro, and 2 with TIMEPARAM_ZERO_GUARD_EN defined.

Source files
------------

// File: rtl/time_param_pkg.sv
// Shared interval codes, default timings and value type for the traffic-light
// controller (register file, sequencing FSM, countdown timer).
package time_param_pkg;

  localparam int TP_WIDTH    = 4;
  localparam int TP_DEF_BASE = 6;
  localparam int TP_DEF_EXT  = 3;
  localparam int TP_DEF_YEL  = 2;

  typedef enum logic [1:0] {
    IDX_BASE = 2'd0,
    IDX_EXT  = 2'd1,
    IDX_YEL  = 2'd2,
    IDX_RSVD = 2'd3
  } interval_e;

  typedef logic [TP_WIDTH-1:0] tval_t;

endpackage

// File: rtl/time_param_reg.sv
// One interval register: async active-low reset to its default, loads din when wen.
// Latency 1 cycle; always accepts a write (no backpressure).
module time_param_reg
  import time_param_pkg::*;
#(
  parameter int               WIDTH = TP_WIDTH,
  parameter logic [WIDTH-1:0] DEF   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= DEF;
    end else if (wen) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/time_parameters.sv
// Run-time programmable base/extended/yellow intervals with a registered read port
// (1-cycle latency, write-through bypass, no backpressure); zero guard under TIMEPARAM_ZERO_GUARD_EN.
module time_parameters
  import time_param_pkg::*;
#(
  parameter int WIDTH    = TP_WIDTH,
  parameter int DEF_BASE = TP_DEF_BASE,
  parameter int DEF_EXT  = TP_DEF_EXT,
  parameter int DEF_YEL  = TP_DEF_YEL
) (
  input  logic             clk,
  input  logic             global_reset,
  input  logic [1:0]       time_param_selector,
  input  logic [WIDTH-1:0] input_time_value,
  input  logic             reprogram,
  input  logic [1:0]       fsm_requested_interval,
  output logic [WIDTH-1:0] output_time_value
);

  localparam logic [WIDTH-1:0] DEF_B = WIDTH'(DEF_BASE);
  localparam logic [WIDTH-1:0] DEF_E = WIDTH'(DEF_EXT);
  localparam logic [WIDTH-1:0] DEF_Y = WIDTH'(DEF_YEL);

  logic             wen_base, wen_ext, wen_yel;
  logic [WIDTH-1:0] wdat_base, wdat_ext, wdat_yel;
  logic [WIDTH-1:0] q_base, q_ext, q_yel;
  logic [WIDTH-1:0] rd_nxt;

  always_comb begin
    wen_base = 1'b0;
    wen_ext  = 1'b0;
    wen_yel  = 1'b0;
    if (reprogram) begin
      case (interval_e'(time_param_selector))
        IDX_BASE: wen_base = 1'b1;
        IDX_EXT:  wen_ext  = 1'b1;
        IDX_YEL:  wen_yel  = 1'b1;
        default:  ;
      endcase
    end
  end

`ifdef TIMEPARAM_ZERO_GUARD_EN
  // A zero-length phase would stall the sequencer, so zero means "use the default".
  assign wdat_base = (input_time_value == '0) ? DEF_B : input_time_value;
  assign wdat_ext  = (input_time_value == '0) ? DEF_E : input_time_value;
  assign wdat_yel  = (input_time_value == '0) ? DEF_Y : input_time_value;
`else
  assign wdat_base = input_time_value;
  assign wdat_ext  = input_time_value;
  assign wdat_yel  = input_time_value;
`endif

  time_param_reg #(.WIDTH(WIDTH), .DEF(DEF_B)) u_base (
    .clk  (clk),
    .rst_n(global_reset),
    .wen  (wen_base),
    .din  (wdat_base),
    .dout (q_base)
  );

  time_param_reg #(.WIDTH(WIDTH), .DEF(DEF_E)) u_ext (
    .clk  (clk),
    .rst_n(global_reset),
    .wen  (wen_ext),
    .din  (wdat_ext),
    .dout (q_ext)
  );

  time_param_reg #(.WIDTH(WIDTH), .DEF(DEF_Y)) u_yel (
    .clk  (clk),
    .rst_n(global_reset),
    .wen  (wen_yel),
    .din  (wdat_yel),
    .dout (q_yel)
  );

  // Same-edge write and read of one register returns the value being written.
  always_comb begin
    rd_nxt = DEF_B;
    case (interval_e'(fsm_requested_interval))
      IDX_BASE: rd_nxt = wen_base ? wdat_base : q_base;
      IDX_EXT:  rd_nxt = wen_ext  ? wdat_ext  : q_ext;
      IDX_YEL:  rd_nxt = wen_yel  ? wdat_yel  : q_yel;
      default:  rd_nxt = DEF_B;
    endcase
  end

  always_ff @(posedge clk or negedge global_reset) begin
    if (!global_reset) begin
      output_time_value <= DEF_B;
    end else begin
      output_time_value <= rd_nxt;
    end
  end

endmodule

// File: tb/tb_time_parameters.sv
// Directed bench for time_parameters: array model of the three intervals checked every
// cycle on the falling edge, plus hand-computed literal expectations after each step.
module tb_time_parameters;

  logic       clk;
  logic       global_reset;
  logic [1:0] time_param_selector;
  logic [3:0] input_time_value;
  logic       reprogram;
  logic [1:0] fsm_requested_interval;
  logic [3:0] output_time_value;

  int checks   = 0;
  int failures = 0;
  bit run      = 0;

  logic [3:0] mdl [3];
  logic [3:0] mdl_out;
  logic [3:0] zero_yel;

  time_parameters dut (
    .clk                   (clk),
    .global_reset          (global_reset),
    .time_param_selector   (time_param_selector),
    .input_time_value      (input_time_value),
    .reprogram             (reprogram),
    .fsm_requested_interval(fsm_requested_interval),
    .output_time_value     (output_time_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // Model: intervals in an array, defaults on reset; the read sees any write on the same edge.
  always @(posedge clk or negedge global_reset) begin
    logic [3:0] wv;
    if (!global_reset) begin
      mdl[0] = 4'd6; mdl[1] = 4'd3; mdl[2] = 4'd2;
      mdl_out = 4'd6;
    end else begin
      wv = input_time_value;
`ifdef TIMEPARAM_ZERO_GUARD_EN
      if (wv == 4'd0 && time_param_selector != 2'd3)
        wv = (time_param_selector == 2'd0) ? 4'd6 : (time_param_selector == 2'd1) ? 4'd3 : 4'd2;
`endif
      if (reprogram && time_param_selector != 2'd3) mdl[time_param_selector] = wv;
      mdl_out = (fsm_requested_interval == 2'd3) ? 4'd6 : mdl[fsm_requested_interval];
    end
  end

  always @(negedge clk) begin
    if (run) begin
      checks++;
      if (output_time_value !== mdl_out) begin
        failures++;
        $display("FAIL model_cycle t=%0t: got %0d required %0d", $time, output_time_value, mdl_out);
      end
    end
  end

  task automatic expect_out(input string name, input logic [3:0] want);
    checks++;
    if (output_time_value !== want) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, output_time_value, want);
    end
  endtask

  // Drive one cycle of inputs, then sample 2 time units after the rising edge.
  task automatic step(input logic wr, input logic [1:0] sel, input logic [3:0] val,
                      input logic [1:0] req);
    reprogram              = wr;
    time_param_selector    = sel;
    input_time_value       = val;
    fsm_requested_interval = req;
    @(posedge clk);
    #2;
  endtask

  initial begin
`ifdef TIMEPARAM_ZERO_GUARD_EN
    zero_yel = 4'd2;
`else
    zero_yel = 4'd0;
`endif
    global_reset = 1'b0;
    reprogram = 1'b0; time_param_selector = 2'd0; input_time_value = 4'd0;
    fsm_requested_interval = 2'd0;
    #1;
    mdl[0] = 4'd6; mdl[1] = 4'd3; mdl[2] = 4'd2; mdl_out = 4'd6;
    run = 1;
    @(posedge clk); #2;
    expect_out("reset_out", 4'd6);
    step(1'b1, 2'd1, 4'd9, 2'd1);
    expect_out("reset_ignores_write", 4'd6);
    global_reset = 1'b1;

    step(1'b0, 2'd0, 4'd0, 2'd0); expect_out("post_reset_base", 4'd6);
    step(1'b0, 2'd0, 4'd0, 2'd1); expect_out("default_ext", 4'd3);
    step(1'b0, 2'd0, 4'd0, 2'd2); expect_out("default_yel", 4'd2);

    step(1'b1, 2'd1, 4'd9, 2'd1); expect_out("ext_bypass", 4'd9);
    step(1'b0, 2'd0, 4'd0, 2'd1); expect_out("ext_held", 4'd9);
    step(1'b0, 2'd0, 4'd0, 2'd0); expect_out("base_untouched", 4'd6);

    step(1'b1, 2'd0, 4'd12, 2'd0); expect_out("base_bypass", 4'd12);
    step(1'b0, 2'd0, 4'd0, 2'd1);  expect_out("ext_still_9", 4'd9);
    step(1'b0, 2'd0, 4'd0, 2'd2);  expect_out("yel_still_2", 4'd2);

    step(1'b1, 2'd3, 4'd15, 2'd3); expect_out("rsvd_read", 4'd6);
    step(1'b0, 2'd0, 4'd0, 2'd0);  expect_out("rsvd_no_base", 4'd12);
    step(1'b0, 2'd0, 4'd0, 2'd1);  expect_out("rsvd_no_ext", 4'd9);
    step(1'b0, 2'd0, 4'd0, 2'd2);  expect_out("rsvd_no_yel", 4'd2);

    step(1'b1, 2'd2, 4'd5, 2'd0);  expect_out("write_other_read", 4'd12);
    step(1'b1, 2'd2, 4'd7, 2'd2);  expect_out("multi_write_1", 4'd7);
    step(1'b1, 2'd2, 4'd8, 2'd2);  expect_out("multi_write_2", 4'd8);
    step(1'b0, 2'd0, 4'd0, 2'd2);  expect_out("multi_write_last", 4'd8);

    // Asynchronous reset mid-cycle, away from any clock edge.
    global_reset = 1'b0;
    #1;
    expect_out("async_reset_out", 4'd6);
    @(posedge clk); #2;
    global_reset = 1'b1;
    step(1'b0, 2'd0, 4'd0, 2'd0);  expect_out("reset_base", 4'd6);
    step(1'b0, 2'd0, 4'd0, 2'd1);  expect_out("reset_ext", 4'd3);
    step(1'b0, 2'd0, 4'd0, 2'd2);  expect_out("reset_yel", 4'd2);

    step(1'b1, 2'd2, 4'd0, 2'd2);  expect_out("zero_bypass", zero_yel);
    step(1'b0, 2'd0, 4'd0, 2'd2);  expect_out("zero_stored", zero_yel);
    step(1'b1, 2'd1, 4'd15, 2'd1); expect_out("ext_max", 4'd15);
    step(1'b0, 2'd0, 4'd0, 2'd3);  expect_out("rsvd_fallback", 4'd6);

    run = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
